// File: rtl/rggen_rtl_pkg.sv
// Shared definitions for the rggen bus bridges: response status codes and
// the APB bridge FSM state encoding.
package rggen_rtl_pkg;

   localparam logic [1:0] OKAY         = 2'b00;
   localparam logic [1:0] EXOKAY       = 2'b01;
   localparam logic [1:0] SLAVE_ERROR  = 2'b10;
   localparam logic [1:0] DECODE_ERROR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESPONSE
   } rggen_apb_bridge_state_e;

endpackage

// File: rtl/rggen_apb_bridge.sv
// External register bus to APB4 master bridge. One request becomes one
// SETUP/ACCESS transfer followed by a single-cycle registered response.
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any input to any output.
module rggen_apb_bridge #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_valid,
   input  logic                      i_write,
   input  logic                      i_read,
   input  logic [ADDRESS_WIDTH-1:0]  i_address,
   input  logic [DATA_WIDTH/8-1:0]   i_strobe,
   input  logic [DATA_WIDTH-1:0]     i_write_data,
   output logic                      o_ready,
   output logic [DATA_WIDTH-1:0]     o_read_data,
   output logic [1:0]                o_status,
   output logic                      o_psel,
   output logic                      o_penable,
   output logic                      o_pwrite,
   output logic [ADDRESS_WIDTH-1:0]  o_paddr,
   output logic [2:0]                o_pprot,
   output logic [DATA_WIDTH/8-1:0]   o_pstrb,
   output logic [DATA_WIDTH-1:0]     o_pwdata,
   input  logic                      i_pready,
   input  logic                      i_pslverr,
   input  logic [DATA_WIDTH-1:0]     i_prdata
);

   import rggen_rtl_pkg::*;

   localparam int SW = DATA_WIDTH / 8;

   rggen_apb_bridge_state_e r_state;
   rggen_apb_bridge_state_e w_next;

   logic                     r_write;
   logic [ADDRESS_WIDTH-1:0] r_addr;
   logic [SW-1:0]            r_strb;
   logic [DATA_WIDTH-1:0]    r_wdata;
   logic [DATA_WIDTH-1:0]    r_rdata;
   logic [1:0]               r_status;

   logic w_busy;
   logic w_busy_wr;
   logic w_unused;

   // A read is simply a request with i_write low; i_read carries no extra info.
   assign w_unused = i_read;

   // State register; reset drops the APB bus immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next-state: valid is only looked at in IDLE, pready only in ACCESS.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:     if (i_valid)  w_next = ST_SETUP;
         ST_SETUP:                  w_next = ST_ACCESS;
         ST_ACCESS:   if (i_pready) w_next = ST_RESPONSE;
         ST_RESPONSE:               w_next = ST_IDLE;
         default:                   w_next = ST_IDLE;
      endcase
   end

   // Capture the exporter's request on acceptance; held for the whole transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_write <= 1'b0;
         r_addr  <= '0;
         r_strb  <= '0;
         r_wdata <= '0;
      end else if (r_state == ST_IDLE && i_valid) begin
         r_write <= i_write;
         r_addr  <= i_address;
         r_strb  <= i_strobe;
         r_wdata <= i_write_data;
      end
   end

   // Capture the slave's completion; write responses carry no data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata  <= '0;
         r_status <= OKAY;
      end else if (r_state == ST_ACCESS && i_pready) begin
         r_rdata  <= r_write ? '0 : i_prdata;
         r_status <= i_pslverr ? SLAVE_ERROR : OKAY;
      end
   end

   assign w_busy    = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
   assign w_busy_wr = w_busy && r_write;

   // APB side: payload is forced to zero outside SETUP/ACCESS, and strobes
   // and write data are zero for reads.
   assign o_psel    = w_busy;
   assign o_penable = (r_state == ST_ACCESS);
   assign o_pwrite  = w_busy_wr;
   assign o_paddr   = w_busy    ? r_addr  : '0;
   assign o_pstrb   = w_busy_wr ? r_strb  : '0;
   assign o_pwdata  = w_busy_wr ? r_wdata : '0;
   assign o_pprot   = 3'b000;

   // Response side: only non-zero during the one RESPONSE cycle.
   assign o_ready     = (r_state == ST_RESPONSE);
   assign o_read_data = o_ready ? r_rdata  : '0;
   assign o_status    = o_ready ? r_status : 2'b00;

endmodule

// File: tb/tb_rggen_apb_bridge.sv
// Randomized bench for rggen_apb_bridge with a transaction-level model that
// predicts every APB and response output each cycle.
module tb_rggen_apb_bridge;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int SW = DW / 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_valid = 1'b0, i_write = 1'b0, i_read = 1'b0;
   logic [AW-1:0] i_address = '0;
   logic [SW-1:0] i_strobe = '0;
   logic [DW-1:0] i_write_data = '0;
   logic          o_ready;
   logic [DW-1:0] o_read_data;
   logic [1:0]    o_status;
   logic          o_psel, o_penable, o_pwrite;
   logic [AW-1:0] o_paddr;
   logic [2:0]    o_pprot;
   logic [SW-1:0] o_pstrb;
   logic [DW-1:0] o_pwdata;
   logic          i_pready = 1'b0, i_pslverr = 1'b0;
   logic [DW-1:0] i_prdata = '0;

   rggen_apb_bridge #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_valid(i_valid), .i_write(i_write), .i_read(i_read),
      .i_address(i_address), .i_strobe(i_strobe), .i_write_data(i_write_data),
      .o_ready(o_ready), .o_read_data(o_read_data), .o_status(o_status),
      .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite),
      .o_paddr(o_paddr), .o_pprot(o_pprot), .o_pstrb(o_pstrb), .o_pwdata(o_pwdata),
      .i_pready(i_pready), .i_pslverr(i_pslverr), .i_prdata(i_prdata)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0, cyc = 0, last_ready = -100, n_xfer = 0;
   logic prev_psel = 1'b0;

   // Model: m_k = cycles into the transfer (1 = setup, >=2 = access), -1 = none.
   int            m_k = -1;
   bit            m_resp = 0;
   bit            m_write = 0;
   logic [AW-1:0] m_addr = '0;
   logic [SW-1:0] m_strb = '0;
   logic [DW-1:0] m_wdata = '0, m_rdata = '0;
   logic [1:0]    m_status = 2'b00;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Advance the model across one clock edge using the inputs present there.
   task automatic model_edge();
      if (!rst_n) begin
         m_k = -1; m_resp = 0;
      end else if (m_resp) begin
         m_resp = 0;
      end else if (m_k < 0) begin
         if (i_valid) begin
            m_k = 1; m_write = i_write; m_addr = i_address;
            m_strb = i_strobe; m_wdata = i_write_data;
         end
      end else if (m_k == 1) begin
         m_k = 2;
      end else if (i_pready) begin
         m_resp = 1; m_k = -1;
         m_rdata = m_write ? '0 : i_prdata;
         m_status = i_pslverr ? 2'b10 : 2'b00;
      end else begin
         m_k++;
      end
   endtask

   task automatic compare();
      bit busy, bw;
      busy = (m_k > 0);
      bw = busy && m_write;
      chk("psel",      o_psel,      busy);
      chk("penable",   o_penable,   m_k >= 2);
      chk("pwrite",    o_pwrite,    bw);
      chk("paddr",     o_paddr,     busy ? m_addr : '0);
      chk("pstrb",     o_pstrb,     bw ? m_strb : '0);
      chk("pwdata",    o_pwdata,    bw ? m_wdata : '0);
      chk("pprot",     o_pprot,     3'b000);
      chk("ready",     o_ready,     m_resp);
      chk("read_data", o_read_data, m_resp ? m_rdata : '0);
      chk("status",    o_status,    m_resp ? m_status : 2'b00);
      if (o_psel && !prev_psel) begin
         n_xfer++;
         chk("idle_gap", (cyc - last_ready) >= 2, 1'b1);
      end
      if (o_ready) last_ready = cyc;
      prev_psel = o_psel;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      compare();
   endtask

   task automatic rand_slave();
      i_pready = 1'($urandom); i_pslverr = 1'($urandom); i_prdata = $urandom;
   endtask

   // Exporter-side request plus a slave that answers after 'waits' stall cycles.
   task automatic do_txn(input bit w, input logic [AW-1:0] a, input logic [SW-1:0] s,
                         input logic [DW-1:0] d, input int waits, input bit err,
                         input logic [DW-1:0] rd, input bit jitter,
                         output int lat, output int pen, output logic [SW-1:0] setup_strb,
                         output logic [DW-1:0] got_rd, output logic [1:0] got_st);
      int wc;
      bit done;
      wc = 0; done = 0; lat = 0; pen = 0;
      setup_strb = '0; got_rd = '0; got_st = 2'b00;
      i_valid = 1'b1; i_write = w; i_read = !w;
      i_address = a; i_strobe = s; i_write_data = d;
      for (int t = 0; t < 60 && !done; t++) begin
         if (m_k >= 2) begin
            i_pready  = (wc == waits);
            i_pslverr = i_pready ? err : 1'($urandom);
            i_prdata  = i_pready ? rd : $urandom;
            wc++;
         end else begin
            rand_slave();
         end
         if (jitter && m_k > 0) i_valid = 1'($urandom);
         step();
         lat++;
         if (o_penable) pen++;
         if (lat == 1) setup_strb = o_pstrb;
         if (m_resp) begin
            done = 1; got_rd = o_read_data; got_st = o_status;
         end
      end
      if (!done) chk("txn_timeout", 1'b0, 1'b1);
      i_valid = 1'b1;
      rand_slave();
      step();
      i_valid = 1'b0; i_write = 1'($urandom); i_address = AW'($urandom);
      i_strobe = SW'($urandom); i_write_data = $urandom;
      rand_slave();
      step();
   endtask

   initial begin
      int lat, pen, n0;
      logic [SW-1:0] ss;
      logic [DW-1:0] rd;
      logic [1:0] st;

      step(); step();
      chk("rst_ready", o_ready, 1'b0);
      chk("rst_psel", o_psel, 1'b0);
      chk("rst_paddr", o_paddr, '0);
      rst_n = 1'b1;
      step();

      // Zero-wait write
      do_txn(1, 8'h10, 4'hF, 32'hDEADBEEF, 0, 0, 32'h0, 0, lat, pen, ss, rd, st);
      chk("wr_latency", lat, 3);
      chk("wr_status", st, 2'b00);
      chk("wr_rdata", rd, 32'h0);
      chk("wr_setup_strb", ss, 4'hF);

      // Read with three wait states
      do_txn(0, 8'h24, 4'hF, 32'h0, 3, 0, 32'h12345678, 0, lat, pen, ss, rd, st);
      chk("rd_latency", lat, 6);
      chk("rd_penable_cycles", pen, 4);
      chk("rd_setup_strb", ss, 4'h0);
      chk("rd_rdata", rd, 32'h12345678);

      // Slave error on the completing cycle
      do_txn(0, 8'h30, 4'hF, 32'h0, 2, 1, 32'hA5A5A5A5, 0, lat, pen, ss, rd, st);
      chk("err_status", st, 2'b10);

      // Back-to-back writes
      n0 = n_xfer;
      do_txn(1, 8'h40, 4'h3, 32'h11112222, 0, 0, 32'h0, 0, lat, pen, ss, rd, st);
      do_txn(1, 8'h44, 4'hC, 32'h33334444, 1, 0, 32'h0, 0, lat, pen, ss, rd, st);
      chk("b2b_xfers", n_xfer - n0, 2);

      // Partial strobe write
      do_txn(1, 8'h08, 4'b0101, 32'hCAFEF00D, 2, 0, 32'h0, 0, lat, pen, ss, rd, st);
      chk("partial_setup_strb", ss, 4'b0101);
      chk("partial_latency", lat, 5);

      // Reset in ACCESS with pready low
      i_valid = 1'b1; i_write = 1'b0; i_read = 1'b1; i_address = 8'h50;
      i_pready = 1'b0;
      step(); step();
      chk("pre_rst_penable", o_penable, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_psel", o_psel, 1'b0);
      chk("arst_penable", o_penable, 1'b0);
      chk("arst_paddr", o_paddr, '0);
      chk("arst_ready", o_ready, 1'b0);
      m_k = -1; m_resp = 0; prev_psel = 1'b0;
      i_valid = 1'b0;
      rand_slave(); step();
      rand_slave(); step();
      rst_n = 1'b1;
      step();
      do_txn(0, 8'h54, 4'hF, 32'h0, 1, 0, 32'h0BADC0DE, 0, lat, pen, ss, rd, st);
      chk("post_rst_rdata", rd, 32'h0BADC0DE);
      chk("post_rst_latency", lat, 4);

      // Randomized traffic, including valid wobbling mid-transfer
      for (int n = 0; n < 60; n++)
         do_txn(1'($urandom), AW'($urandom), SW'($urandom), $urandom,
                int'($urandom_range(0, 5)), 1'($urandom), $urandom, 1'($urandom),
                lat, pen, ss, rd, st);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
